// File: rtl/traffic_density_sel.sv
// -----------------------------------------------------------------------------
// traffic_density_sel
//
// Purpose:
//   Turns per-pixel vehicle detections into a registered light/heavy traffic
//   select. Vehicle pixels inside the ROI are counted per frame. The frame
//   counts are summed over a window of FRAME_WIN frames, and the window
//   average drives a hysteresis decision. That decision must agree for
//   CONFIRM consecutive windows before traffic_sel flips.
//
// Ports:
//   clk              system clock (only clock)
//   reset            asynchronous, active-high reset
//   i_frame_start    one-cycle pulse at the start of each video frame
//   i_pix_en         current pixel is valid and inside the ROI
//   i_pix_hit        current pixel is classified as vehicle
//   traffic_sel      registered flow state: 0 = light, 1 = heavy
//   o_density        last window average, in hits per frame
//   o_density_valid  one-cycle pulse in the cycle that updates o_density and
//                    traffic_sel (new values visible the following cycle)
// -----------------------------------------------------------------------------
module traffic_density_sel #(
   parameter int CNT_W     = 20,
   parameter int FRAME_WIN = 8,
   parameter int HIGH_TH   = 20000,
   parameter int LOW_TH    = 8000,
   parameter int CONFIRM   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_frame_start,
   input  logic             i_pix_en,
   input  logic             i_pix_hit,
   output logic             traffic_sel,
   output logic [CNT_W-1:0] o_density,
   output logic             o_density_valid
);

   localparam int WIN_LOG = $clog2(FRAME_WIN);
   localparam int ACC_W   = CNT_W + WIN_LOG;
   localparam int CONF_W  = $clog2(CONFIRM + 1);

   localparam logic [CNT_W-1:0]   HIGH_C     = CNT_W'(HIGH_TH);
   localparam logic [CNT_W-1:0]   LOW_C      = CNT_W'(LOW_TH);
   localparam logic [WIN_LOG-1:0] LAST_IDX   = WIN_LOG'(FRAME_WIN - 1);
   localparam logic [CONF_W-1:0]  CONF_LAST  = CONF_W'(CONFIRM - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_EVAL  = 2'd2;

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_frame_cnt;
   logic [ACC_W-1:0]   r_acc;
   logic [WIN_LOG-1:0] r_frame_idx;
   logic [ACC_W-1:0]   r_win_sum;
   logic [CONF_W-1:0]  r_confirm;
   logic               r_traffic_sel;
   logic [CNT_W-1:0]   r_density;

   logic               w_hit;
   logic               w_cnt_max;
   logic [ACC_W-1:0]   w_frame_sum;
   logic [CNT_W-1:0]   w_avg;
   logic               w_cand;

   assign w_hit       = i_pix_en & i_pix_hit;
   assign w_cnt_max   = &r_frame_cnt;
   assign w_frame_sum = r_acc + ACC_W'(r_frame_cnt);
   // The window sum holds at most FRAME_WIN * (2^CNT_W - 1). Dropping the low
   // WIN_LOG bits is the truncating divide and leaves exactly CNT_W bits.
   assign w_avg       = r_win_sum[ACC_W-1:WIN_LOG];
   // Mid-band averages keep the current state as the candidate. This means
   // they never extend a streak toward a flip.
   assign w_cand      = (w_avg >= HIGH_C) ? 1'b1 :
                        ((w_avg < LOW_C) ? 1'b0 : r_traffic_sel);

   // Per-frame hit counter. A hit in the same cycle as i_frame_start
   // belongs to the new frame, so the counter restarts at 0 or 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_cnt <= '0;
      end else if (i_frame_start) begin
         r_frame_cnt <= CNT_W'(w_hit);
      end else if ((r_state != ST_IDLE) && w_hit && !w_cnt_max) begin
         r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
   end

   // Window sequencing and decision
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_acc         <= '0;
         r_frame_idx   <= '0;
         r_win_sum     <= '0;
         r_confirm     <= '0;
         r_traffic_sel <= 1'b0;
         r_density     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // The arming pulse only opens the first frame.
               if (i_frame_start) begin
                  r_state     <= ST_ACCUM;
                  r_acc       <= '0;
                  r_frame_idx <= '0;
               end
            end

            ST_ACCUM: begin
               if (i_frame_start) begin
                  if (r_frame_idx == LAST_IDX) begin
                     r_win_sum   <= w_frame_sum;
                     r_acc       <= '0;
                     r_frame_idx <= '0;
                     r_state     <= ST_EVAL;
                  end else begin
                     r_acc       <= w_frame_sum;
                     r_frame_idx <= r_frame_idx + WIN_LOG'(1);
                  end
               end
            end

            ST_EVAL: begin
               r_state   <= ST_ACCUM;
               r_density <= w_avg;
               // The accumulator was just cleared and the index is 0.
               // A frame boundary here is therefore ordinary accumulation
               // and can never close a window (FRAME_WIN >= 2).
               if (i_frame_start) begin
                  r_acc       <= w_frame_sum;
                  r_frame_idx <= r_frame_idx + WIN_LOG'(1);
               end
               if (w_cand != r_traffic_sel) begin
                  if (r_confirm == CONF_LAST) begin
                     r_traffic_sel <= w_cand;
                     r_confirm     <= '0;
                  end else begin
                     r_confirm <= r_confirm + CONF_W'(1);
                  end
               end else begin
                  r_confirm <= '0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign traffic_sel     = r_traffic_sel;
   assign o_density       = r_density;
   assign o_density_valid = (r_state == ST_EVAL);

endmodule

// File: tb/tb_traffic_density_sel.sv
// -----------------------------------------------------------------------------
// tb_traffic_density_sel
//
// Self-checking bench for traffic_density_sel. The DUT uses CNT_W=8,
// FRAME_WIN=4, HIGH_TH=100, LOW_TH=50 and CONFIRM=2.
//
// The reference model tracks frame counts in a queue. It closes a window
// once FRAME_WIN completed frames are present, then applies the
// hysteresis/confirm rule with plain integers. Every cycle checks the valid
// pulse, o_density and traffic_sel against the model. Directed constants
// cover the key scenarios.
// -----------------------------------------------------------------------------
module tb_traffic_density_sel;

   localparam int CNT_W     = 8;
   localparam int FRAME_WIN = 4;
   localparam int HIGH_TH   = 100;
   localparam int LOW_TH    = 50;
   localparam int CONFIRM   = 2;
   localparam int MAXC      = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             i_frame_start = 1'b0;
   logic             i_pix_en = 1'b0;
   logic             i_pix_hit = 1'b0;
   logic             traffic_sel;
   logic [CNT_W-1:0] o_density;
   logic             o_density_valid;

   traffic_density_sel #(
      .CNT_W     (CNT_W),
      .FRAME_WIN (FRAME_WIN),
      .HIGH_TH   (HIGH_TH),
      .LOW_TH    (LOW_TH),
      .CONFIRM   (CONFIRM)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .i_frame_start   (i_frame_start),
      .i_pix_en        (i_pix_en),
      .i_pix_hit       (i_pix_hit),
      .traffic_sel     (traffic_sel),
      .o_density       (o_density),
      .o_density_valid (o_density_valid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit m_armed    = 0;
   int m_cur      = 0;
   int m_win[$];
   int m_sel      = 0;
   int m_streak   = 0;
   bit m_pend     = 0;
   int m_pend_den = 0;
   int m_pend_sel = 0;
   int m_vis_den  = 0;
   int m_vis_sel  = 0;
   int n_win      = 0;
   int n_valid_seen = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive the inputs, advance the model, then check the
   // outputs 1 time unit after the rising edge.
   task automatic tick(input bit fs, input bit en, input bit hit);
      bit upd;
      int upd_den, upd_sel;
      bit exp_valid;
      int sum, avg, cand;
      upd     = m_pend;
      upd_den = m_pend_den;
      upd_sel = m_pend_sel;
      m_pend  = 0;
      exp_valid = 0;
      i_frame_start = fs;
      i_pix_en      = en;
      i_pix_hit     = hit;
      if (fs) begin
         if (!m_armed) begin
            m_armed = 1;
            m_cur   = (en && hit) ? 1 : 0;
         end else begin
            m_win.push_back(m_cur);
            m_cur = (en && hit) ? 1 : 0;
            if (m_win.size() == FRAME_WIN) begin
               sum = 0;
               foreach (m_win[k]) sum += m_win[k];
               avg  = sum / FRAME_WIN;
               cand = (avg >= HIGH_TH) ? 1 : ((avg < LOW_TH) ? 0 : m_sel);
               if (cand != m_sel) begin
                  m_streak++;
                  if (m_streak == CONFIRM) begin
                     m_sel    = cand;
                     m_streak = 0;
                  end
               end else begin
                  m_streak = 0;
               end
               m_win.delete();
               exp_valid  = 1;
               m_pend     = 1;
               m_pend_den = avg;
               m_pend_sel = m_sel;
               n_win++;
               $display("window %0d: frame sum=%0d avg=%0d expected sel=%0d", n_win, sum, avg, m_sel);
            end
         end
      end else if (m_armed && en && hit && m_cur < MAXC) begin
         m_cur++;
      end
      @(posedge clk);
      #1;
      if (upd) begin
         m_vis_den = upd_den;
         m_vis_sel = upd_sel;
      end
      if (o_density_valid === 1'b1) n_valid_seen++;
      check_val("density_valid", int'(o_density_valid), int'(exp_valid));
      check_val("o_density", int'(o_density), m_vis_den);
      check_val("traffic_sel", int'(traffic_sel), m_vis_sel);
   endtask

   // One frame of length len. The first n cycles have a valid hit,
   // including the i_frame_start cycle.
   task automatic do_frame(input int n, input int len);
      for (int i = 0; i < len; i++) tick(i == 0, i < n, i < n);
   endtask

   task automatic do_frame_rand(input int pct, input int len);
      for (int i = 0; i < len; i++)
         tick(i == 0, ($urandom % 4) != 0, $urandom_range(0, 99) < pct);
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic do_reset();
      i_frame_start = 0;
      i_pix_en      = 0;
      i_pix_hit     = 0;
      #3 reset = 1'b1;
      #1;
      check_val("async_rst_sel", int'(traffic_sel), 0);
      check_val("async_rst_density", int'(o_density), 0);
      check_val("async_rst_valid", int'(o_density_valid), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      m_armed  = 0;
      m_cur    = 0;
      m_win.delete();
      m_sel    = 0;
      m_streak = 0;
      m_pend   = 0;
      m_vis_den = 0;
      m_vis_sel = 0;
   endtask

   int hyst[5] = '{70, 40, 70, 40, 40};
   int coin[4] = '{3, 4, 5, 6};
   int valid_before;

   initial begin
      // Power-on reset
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_val("reset_sel", int'(traffic_sel), 0);
      check_val("reset_density", int'(o_density), 0);
      check_val("reset_valid", int'(o_density_valid), 0);

      // The arming pulse carries a hit and produces no window output.
      do_frame(120, 130);
      check_val("arm_no_valid", n_valid_seen, 0);
      do_frame(120, 130);
      do_frame(120, 130);
      do_frame(120, 130);
      do_frame(120, 130);          // closes window 1 (avg 120)
      check_val("w1_density", int'(o_density), 120);
      check_val("w1_sel_hold", int'(traffic_sel), 0);
      check_val("w1_single_pulse", n_valid_seen, 1);
      do_frame(120, 130);
      do_frame(120, 130);
      do_frame(120, 130);

      // Hysteresis: windows 70, 40, 70, 40, 40. The first frame of each
      // window also closes the window before it.
      for (int w = 0; w < 5; w++) begin
         for (int f = 0; f < 4; f++) do_frame(hyst[w], 100);
         if (w == 0) check_val("w2_sel_heavy", int'(traffic_sel), 1);
      end
      check_val("hyst_hold", int'(traffic_sel), 1);

      // Coincident-hit frames of 3, 4, 5, 6; the first one closes the final 40.
      for (int f = 0; f < 4; f++) begin
         do_frame(coin[f], 20);
         if (f == 0) begin
            check_val("hyst_release", int'(traffic_sel), 0);
            check_val("hyst_density", int'(o_density), 40);
         end
      end

      // Saturation: 300 hits per frame saturate at 255.
      for (int w = 0; w < 2; w++) begin
         for (int f = 0; f < 4; f++) begin
            do_frame(300, 300);
            if (w == 0 && f == 0) check_val("coin_density", int'(o_density), 4);
            if (w == 1 && f == 0) begin
               check_val("sat_density", int'(o_density), 255);
               check_val("sat_sel_first", int'(traffic_sel), 0);
            end
         end
      end
      do_frame(10, 50);            // closes the second saturated window
      check_val("sat_sel_heavy", int'(traffic_sel), 1);
      check_val("sat_density2", int'(o_density), 255);

      // Mid-window asynchronous reset
      do_frame(10, 50);
      for (int i = 0; i < 7; i++) tick(0, 1, 1);
      do_reset();
      valid_before = n_valid_seen;
      for (int f = 0; f < 4; f++) do_frame(20, 40);
      check_val("rearm_no_valid", n_valid_seen - valid_before, 0);
      do_frame(20, 40);
      check_val("rearm_first_valid", n_valid_seen - valid_before, 1);
      check_val("rearm_density", int'(o_density), 20);
      check_val("rearm_sel", int'(traffic_sel), 0);

      // Randomized windows across the light, mid-band and heavy bands
      for (int w = 0; w < 10; w++) begin
         int pct;
         case ($urandom_range(0, 2))
            0:       pct = $urandom_range(5, 30);
            1:       pct = $urandom_range(45, 75);
            default: pct = $urandom_range(90, 100);
         endcase
         for (int f = 0; f < 4; f++) do_frame_rand(pct, 150);
      end
      do_frame_rand(50, 10);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_density_sel.md
Name: traffic_density_sel

Overview:
- Upstream stage of the signal control unit: turns per-pixel vehicle detections from the video-processing path into the registered 1-bit traffic-flow select that drives signal timing.
- Counts vehicle pixels per frame inside the ROI (region of interest) and averages them over a window of frames.
- Applies hysteresis plus multi-window confirmation so traffic_sel never chatters.
- Publishes the averaged density for VGA overlay/debug.

Parameters:
- CNT_W, 20, width of per-frame hit counter, average and thresholds.
- FRAME_WIN, 8, frames per averaging window; power of two, ≥ 2.
- HIGH_TH, 20000, average ≥ HIGH_TH is a heavy-traffic candidate.
- LOW_TH, 8000, average < LOW_TH is a light-traffic candidate; LOW_TH ≤ HIGH_TH.
- CONFIRM, 2, consecutive agreeing windows required to flip traffic_sel; ≥ 1.

Ports:
- clk  in  1  system clock, the only clock.
- reset  in  1  asynchronous, active-high reset.
- i_frame_start  in  1  one-cycle pulse at start of each video frame.
- i_pix_en  in  1  current pixel is valid and inside the ROI.
- i_pix_hit  in  1  current pixel is classified as vehicle.
- traffic_sel  out  1  registered flow state: 0 = light, 1 = heavy.
- o_density  out  CNT_W  last window average, in hits per frame.
- o_density_valid  out  1  one-cycle pulse when o_density and traffic_sel are updated.

Behaviour:
- Reset (asynchronous, any time, including mid-window or mid-EVAL):
  - State = IDLE.
  - Frame counter, accumulator, frame index and confirm counter = 0.
  - traffic_sel = 0, o_density = 0, o_density_valid = 0.
- Frame counter:
  - Increments on every cycle with i_pix_en & i_pix_hit.
  - Saturates at 2^CNT_W−1; never wraps.
- States:
  - IDLE: pixels are ignored. The first i_frame_start arms the block: frame counter cleared, frame index = 0, go to ACCUM. No window output from this pulse.
  - ACCUM: on i_frame_start, add the frame count to the accumulator (width CNT_W+log2(FRAME_WIN), cannot overflow), clear the frame counter, increment frame index.
    - When the index reaches FRAME_WIN: latch the accumulator+count sum into win_sum, clear accumulator and index, go to EVAL.
  - EVAL: exactly one cycle, then always ACCUM.
    - avg = win_sum >> log2(FRAME_WIN), truncating.
    - o_density <= avg; o_density_valid = 1 this cycle only.
- Frame-boundary rules:
  - A hit coincident with i_frame_start counts toward the new frame.
  - Frame counting and accumulation continue during EVAL. An i_frame_start during EVAL is accumulated normally.
- Decision, evaluated in EVAL with cand = avg ≥ HIGH_TH ? 1 : (avg < LOW_TH ? 0 : traffic_sel):
  - If cand ≠ traffic_sel: confirm counter increments. On reaching CONFIRM, traffic_sel <= cand and confirm = 0.
  - Otherwise confirm = 0; a mid-band window breaks the streak.
  - traffic_sel changes only in an EVAL cycle and becomes visible the cycle after o_density_valid, together with the new o_density.
- Latency: the window-closing i_frame_start at cycle t gives o_density_valid at t+1 and registered outputs updated at t+2.

Test Plan:
- Assert reset, then a single i_frame_start with hits -> all outputs 0, no o_density_valid pulse, block armed.
- Params FRAME_WIN=4, HIGH_TH=100, LOW_TH=50, CONFIRM=2; 4 frames × 120 hits:
  - Closing pulse -> o_density=120, single valid pulse, traffic_sel stays 0.
  - Repeat the window -> traffic_sel=1.
- From traffic_sel=1, window averages 70, 40, 70, 40, 40 -> traffic_sel holds 1 until the final 40 window, then 0 (mid-band windows reset confirm).
- Frames of 3, 4, 5, 6 hits, with one hit coincident with each i_frame_start -> o_density=(sum)>>2, coincident hits land in the next frame.
- CNT_W=8: hold i_pix_en=i_pix_hit=1 for 300 cycles per frame -> each frame count = 255, o_density=255.
- Assert reset mid-window with traffic_sel=1 -> all cleared; the next i_frame_start only re-arms, and the first valid pulse comes FRAME_WIN frames later.
